// File: rtl/regfile_write_scheduler_pkg.sv
// Shared decode-stage definitions used by the register file write scheduler.
package regfile_write_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Starvation tracking for a buffered MDU result that WB keeps pre-empting.
    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } starve_state_e;

endpackage

// File: rtl/regfile_write_scheduler_reg_scoreboard.sv
// Busy vector for registers with an outstanding MDU result.
// r0 is never busy. A set and a clear of the same register in one cycle
// leave it busy: the set belongs to a newer MDU op than the result draining.
module reg_scoreboard
    import regfile_write_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    input  logic [REG_ADDR_W-1:0] rd_addr_c,
    output logic                  rd_busy_a,
    output logic                  rd_busy_b,
    output logic                  rd_busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear first so a same-register set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (reset) begin
            busy_d = '0;
        end
    end

    // Busy state register.
    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    // Three combinational read ports for the decode hazard check.
    always_comb begin
        rd_busy_a = busy_q[rd_addr_a];
        rd_busy_b = busy_q[rd_addr_b];
        rd_busy_c = busy_q[rd_addr_c];
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file write port between pipeline WB (always wins) and
// a one-entry MDU result buffer, tracks pending MDU destinations for decode
// hazard stalls, and stalls the front end when a buffered result starves.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic [4:0]  dec_rd,
    input  logic        dec_we,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    logic                  wb_claim;
    logic                  drain;
    logic                  buf_load;
    logic                  hazard_stall;
    logic                  busy_rs;
    logic                  busy_rt;
    logic                  busy_rd;
    logic                  sb_set;

    logic                  buf_valid_q, buf_valid_d;
    logic [REG_ADDR_W-1:0] buf_addr_q,  buf_addr_d;
    logic [DATA_W-1:0]     buf_data_q,  buf_data_d;

    starve_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    // Port arbitration: WB claims first, the buffer drains on idle cycles,
    // and a draining buffer can take a new result in the same cycle.
    always_comb begin
        wb_claim  = wb_we && (wb_addr != '0);
        drain     = !reset && buf_valid_q && !wb_claim;
        mdu_ready = !reset && (!buf_valid_q || drain);
        buf_load  = mdu_valid && mdu_ready;
    end

    // Write port mux; outputs are forced quiet while in reset.
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (!reset) begin
            if (wb_claim) begin
                rf_we   = 1'b1;
                rf_addr = wb_addr;
                rf_data = wb_data;
            end else if (drain) begin
                rf_we   = 1'b1;
                rf_addr = buf_addr_q;
                rf_data = buf_data_q;
            end
        end
    end

    // MDU result buffer next state; reset discards any held result.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (buf_load) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = mdu_addr;
            buf_data_d  = mdu_data;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end
        if (reset) begin
            buf_valid_d = 1'b0;
        end
    end

    // Buffer registers; address/data need no reset since valid qualifies them.
    always_ff @(posedge clk) begin
        buf_valid_q <= buf_valid_d;
        buf_addr_q  <= buf_addr_d;
        buf_data_q  <= buf_data_d;
    end

    // Starvation FSM: count consecutive blocked cycles of the buffered result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            NORMAL: begin
                if (buf_valid_q && wb_claim) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (cnt_d >= CNT_W'(STARVE_LIMIT)) ? STARVED : WAIT;
                end
            end
            WAIT: begin
                if (drain) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d >= CNT_W'(STARVE_LIMIT)) begin
                        state_d = STARVED;
                    end
                end
            end
            STARVED: begin
                if (drain) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = '0;
            end
        endcase
        if (reset) begin
            state_d = NORMAL;
            cnt_d   = '0;
        end
    end

    // Starvation FSM state register.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // Front-end stall and scoreboard set qualification.
    always_comb begin
        hazard_stall = busy_rs || busy_rt || (dec_we && busy_rd);
        stall        = !reset && (hazard_stall || (state_q == STARVED));
        sb_set       = issue_valid && (issue_addr != '0) && !stall;
    end

    reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (sb_set),
        .set_addr  (issue_addr),
        .clr_en    (drain),
        .clr_addr  (buf_addr_q),
        .rd_addr_a (dec_rs),
        .rd_addr_b (dec_rt),
        .rd_addr_c (dec_rd),
        .rd_busy_a (busy_rs),
        .rd_busy_b (busy_rt),
        .rd_busy_c (busy_rd)
    );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios with fixed expectations
// plus randomized traffic, both scored against a behavioural model.
module tb_regfile_write_scheduler;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_addr = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [4:0]  dec_rs = '0;
    logic [4:0]  dec_rt = '0;
    logic [4:0]  dec_rd = '0;
    logic        dec_we = 1'b0;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    // Pending stimulus, applied just after the next rising edge by cyc().
    logic        p_reset, p_wb_we, p_mdu_valid, p_issue_valid, p_dec_we;
    logic [4:0]  p_wb_addr, p_mdu_addr, p_issue_addr, p_dec_rs, p_dec_rt, p_dec_rd;
    logic [31:0] p_wb_data, p_mdu_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic we;
        logic stall;
        logic ready;
    } st_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    st_t exp_st[$];
    wr_t exp_wr[$];
    st_t mon_st;
    wr_t mon_wr;

    // Reference model state: held result, pending-register set, blocked count.
    bit          m_buf_valid;
    logic [4:0]  m_buf_addr;
    logic [31:0] m_buf_data;
    bit          m_busy [32];
    int          m_blocked;
    bit          m_starved;

    regfile_write_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .mdu_valid   (mdu_valid),
        .mdu_addr    (mdu_addr),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .dec_rd      (dec_rd),
        .dec_we      (dec_we),
        .stall       (stall),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_p();
        p_reset = 1'b0; p_wb_we = 1'b0; p_mdu_valid = 1'b0; p_issue_valid = 1'b0; p_dec_we = 1'b0;
        p_wb_addr = '0; p_mdu_addr = '0; p_issue_addr = '0;
        p_dec_rs = '0; p_dec_rt = '0; p_dec_rd = '0;
        p_wb_data = '0; p_mdu_data = '0;
    endtask

    // Model one cycle from the rules: predict this cycle's outputs, then advance.
    task automatic model_step();
        bit  claim, drn, rdy, hz, stl;
        st_t s;
        wr_t w;
        if (reset) begin
            s = '{1'b0, 1'b0, 1'b0};
            exp_st.push_back(s);
            m_buf_valid = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
            m_blocked = 0;
            m_starved = 0;
            return;
        end
        claim = wb_we && (wb_addr != 0);
        drn   = m_buf_valid && !claim;
        rdy   = !m_buf_valid || drn;
        hz    = m_busy[dec_rs] || m_busy[dec_rt] || (dec_we && m_busy[dec_rd]);
        stl   = hz || m_starved;
        s.we = claim || drn; s.stall = stl; s.ready = rdy;
        exp_st.push_back(s);
        if (claim) begin
            w.addr = wb_addr; w.data = wb_data; exp_wr.push_back(w);
        end else if (drn) begin
            w.addr = m_buf_addr; w.data = m_buf_data; exp_wr.push_back(w);
        end
        if (drn) begin
            m_busy[m_buf_addr] = 0;
            m_blocked = 0;
            m_starved = 0;
        end else if (m_buf_valid) begin
            m_blocked++;
            if (m_blocked >= STARVE_LIMIT) m_starved = 1;
        end
        if (issue_valid && issue_addr != 0 && !stl) m_busy[issue_addr] = 1;
        if (mdu_valid && rdy) begin
            m_buf_valid = 1; m_buf_addr = mdu_addr; m_buf_data = mdu_data;
        end else if (drn) begin
            m_buf_valid = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        reset = p_reset; wb_we = p_wb_we; wb_addr = p_wb_addr; wb_data = p_wb_data;
        mdu_valid = p_mdu_valid; mdu_addr = p_mdu_addr; mdu_data = p_mdu_data;
        issue_valid = p_issue_valid; issue_addr = p_issue_addr;
        dec_rs = p_dec_rs; dec_rt = p_dec_rt; dec_rd = p_dec_rd; dec_we = p_dec_we;
        model_step();
        #2;
    endtask

    // Monitor: per-cycle status from one queue, written data from another.
    always @(negedge clk) begin
        if (exp_st.size() > 0) begin
            mon_st = exp_st.pop_front();
            check("mon_stall", 32'(stall), 32'(mon_st.stall));
            check("mon_mdu_ready", 32'(mdu_ready), 32'(mon_st.ready));
            check("mon_rf_we", 32'(rf_we), 32'(mon_st.we));
            if (!mon_st.we) begin
                check("mon_idle_addr", 32'(rf_addr), 32'd0);
                check("mon_idle_data", rf_data, 32'd0);
            end
        end
        if (rf_we) begin
            if (exp_wr.size() == 0) begin
                check("mon_unexpected_write", 32'(rf_we), 32'd0);
            end else begin
                mon_wr = exp_wr.pop_front();
                check("mon_wr_addr", 32'(rf_addr), 32'(mon_wr.addr));
                check("mon_wr_data", rf_data, mon_wr.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr_p();
        // Reset state
        p_reset = 1'b1;
        cyc();
        cyc();
        p_dec_rs = 5'd3;
        cyc();
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mdu_ready", 32'(mdu_ready), 32'd0);
        clr_p();
        cyc();
        check("post_rst_ready", 32'(mdu_ready), 32'd1);

        // Idle MDU drain of r5
        clr_p(); p_issue_valid = 1; p_issue_addr = 5; cyc();
        clr_p(); p_dec_rs = 5; cyc();
        check("drain_busy5_stall", 32'(stall), 32'd1);
        clr_p(); p_dec_rs = 5; p_mdu_valid = 1; p_mdu_addr = 5; p_mdu_data = 32'h1234; cyc();
        check("drain_accept_ready", 32'(mdu_ready), 32'd1);
        check("drain_no_pass_through", 32'(rf_we), 32'd0);
        clr_p(); p_dec_rs = 5; cyc();
        check("drain_rf_we", 32'(rf_we), 32'd1);
        check("drain_rf_addr", 32'(rf_addr), 32'd5);
        check("drain_rf_data", rf_data, 32'h1234);
        clr_p(); p_dec_rs = 5; cyc();
        check("drain_busy5_cleared", 32'(stall), 32'd0);

        // WB priority over buffered r7
        clr_p(); p_issue_valid = 1; p_issue_addr = 7; cyc();
        clr_p(); p_mdu_valid = 1; p_mdu_addr = 7; p_mdu_data = 32'h77; cyc();
        clr_p(); p_wb_we = 1; p_wb_addr = 3; p_wb_data = 32'hAA; cyc();
        check("prio_wb_addr", 32'(rf_addr), 32'd3);
        check("prio_wb_data", rf_data, 32'hAA);
        check("prio_mdu_ready", 32'(mdu_ready), 32'd0);
        clr_p(); cyc();
        check("prio_mdu_addr", 32'(rf_addr), 32'd7);
        check("prio_mdu_data", rf_data, 32'h77);

        // RAW then WAW on r9
        clr_p(); p_issue_valid = 1; p_issue_addr = 9; cyc();
        clr_p(); p_dec_rs = 9; cyc();
        check("raw_stall", 32'(stall), 32'd1);
        clr_p(); p_dec_rd = 9; p_dec_we = 1; cyc();
        check("waw_stall", 32'(stall), 32'd1);
        clr_p(); p_dec_rd = 9; cyc();
        check("rd_no_we_no_stall", 32'(stall), 32'd0);
        clr_p(); p_dec_rs = 9; p_mdu_valid = 1; p_mdu_addr = 9; p_mdu_data = 32'h99; cyc();
        clr_p(); p_dec_rs = 9; cyc();
        check("raw_drain_cycle_stall", 32'(stall), 32'd1);
        check("raw_drain_addr", 32'(rf_addr), 32'd9);
        clr_p(); p_dec_rs = 9; cyc();
        check("raw_released", 32'(stall), 32'd0);

        // Starvation of buffered r4
        clr_p(); p_issue_valid = 1; p_issue_addr = 4; cyc();
        clr_p(); p_wb_we = 1; p_wb_addr = 1; p_mdu_valid = 1; p_mdu_addr = 4; p_mdu_data = 32'h44; cyc();
        for (int i = 1; i <= STARVE_LIMIT; i++) begin
            clr_p(); p_wb_we = 1; p_wb_addr = 1; p_wb_data = 32'(i); cyc();
            check("starve_not_yet", 32'(stall), 32'd0);
            check("starve_blocked_ready", 32'(mdu_ready), 32'd0);
        end
        clr_p(); p_wb_we = 1; p_wb_addr = 1; cyc();
        check("starve_stall", 32'(stall), 32'd1);
        clr_p(); cyc();
        check("starve_drain_addr", 32'(rf_addr), 32'd4);
        check("starve_drain_data", rf_data, 32'h44);
        clr_p(); cyc();
        check("starve_released", 32'(stall), 32'd0);

        // Set/clear collision on r6
        clr_p(); p_issue_valid = 1; p_issue_addr = 6; cyc();
        clr_p(); p_mdu_valid = 1; p_mdu_addr = 6; p_mdu_data = 32'h66; cyc();
        clr_p(); p_issue_valid = 1; p_issue_addr = 6; cyc();
        check("collide_drain_addr", 32'(rf_addr), 32'd6);
        clr_p(); p_dec_rt = 6; cyc();
        check("collide_busy_kept", 32'(stall), 32'd1);
        clr_p(); p_mdu_valid = 1; p_mdu_addr = 6; p_mdu_data = 32'h67; cyc();
        clr_p(); cyc();
        clr_p(); p_dec_rt = 6; cyc();
        check("collide_busy_cleared", 32'(stall), 32'd0);

        // Reset with r2 buffered and busy
        clr_p(); p_issue_valid = 1; p_issue_addr = 2; cyc();
        clr_p(); p_mdu_valid = 1; p_mdu_addr = 2; p_mdu_data = 32'h22; cyc();
        clr_p(); p_reset = 1; p_dec_rs = 2; cyc();
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        check("midrst_rf_addr", 32'(rf_addr), 32'd0);
        check("midrst_rf_data", rf_data, 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_ready", 32'(mdu_ready), 32'd0);
        clr_p(); p_dec_rs = 2; cyc();
        check("midrst_after_ready", 32'(mdu_ready), 32'd1);
        check("midrst_after_busy", 32'(stall), 32'd0);
        check("midrst_no_write", 32'(rf_we), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clr_p();
            p_reset       = ($urandom_range(0, 299) == 0);
            p_wb_we       = ($urandom_range(0, 9) < 6);
            p_wb_addr     = 5'($urandom_range(0, 31));
            p_wb_data     = $urandom;
            p_mdu_valid   = ($urandom_range(0, 9) < 5);
            p_mdu_addr    = 5'($urandom_range(0, 7));
            p_mdu_data    = $urandom;
            p_issue_valid = ($urandom_range(0, 9) < 4);
            p_issue_addr  = 5'($urandom_range(0, 7));
            p_dec_rs      = 5'($urandom_range(0, 15));
            p_dec_rt      = 5'($urandom_range(0, 15));
            p_dec_rd      = 5'($urandom_range(0, 15));
            p_dec_we      = 1'($urandom_range(0, 1));
            cyc();
        end

        clr_p();
        cyc();
        @(negedge clk);
        #1;
        check("end_status_queue_empty", 32'(exp_st.size()), 32'd0);
        check("end_write_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
